// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between the team's master and the register-bank slave.
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [2:0]                AWPROT;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [2:0]                ARPROT;
  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, independent read and
// write FSMs, SLVERR on addresses past the bank, contents exported on regs_o.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  axi_lite_slave_regs_if.slave           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;
  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_DATA    = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Any address bit at or above the bank span makes the access out of range.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ~|(a >> (LSB + IDX_W));
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [0:0]            w_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [1:0]            bresp;

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  unused_ok;

  assign bus.AWREADY = (w_state == W_COLLECT) && !aw_held;
  assign bus.WREADY  = (w_state == W_COLLECT) && !w_held;
  assign bus.BVALID  = (w_state == W_RESP);
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = (r_state == R_IDLE);
  assign bus.RVALID  = (r_state == R_DATA);
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  // A half that was accepted earlier comes from the holding register, the other from the bus.
  assign commit  = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr : bus.AWADDR;
  assign wr_data = w_held ? w_data : bus.WDATA;
  assign wr_strb = w_held ? w_strb : bus.WSTRB;
  assign wr_idx  = wr_addr[LSB +: IDX_W];
  assign rd_idx  = bus.ARADDR[LSB +: IDX_W];

  assign unused_ok = &{1'b0, bus.AWPROT, bus.ARPROT};

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_addr <= bus.AWADDR;
    if (w_hs) begin
      w_data <= bus.WDATA;
      w_strb <= bus.WSTRB;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else if (w_state == W_COLLECT) begin
      if (commit) begin
        w_state <= W_RESP;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp   <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end else if (bus.BREADY) begin
      w_state <= W_COLLECT;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && addr_ok(wr_addr)) begin
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Read samples regs before any same-edge write lands, so a collision returns old data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        r_state <= R_DATA;
        rdata   <= addr_ok(bus.ARADDR) ? regs[rd_idx] : '0;
        rresp   <= addr_ok(bus.ARADDR) ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (bus.RREADY) begin
      r_state <= R_IDLE;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs (32-bit data, 16 registers).
module tb_axi_lite_slave_regs;
  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [511:0] regs_o;
  logic [511:0] exp_regs;
  int           n_cmp = 0;
  int           n_err = 0;

  axi_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .regs_o  (regs_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // AW and W on the same cycle; caller sets exp_regs to the post-write contents.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp, input string tag);
    bus.AWVALID = 1'b1; bus.AWADDR = a;
    bus.WVALID  = 1'b1; bus.WDATA  = d; bus.WSTRB = s;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk({tag, ".bvalid"}, bus.BVALID, 1);
    chk({tag, ".bresp"},  bus.BRESP,  resp);
    chk({tag, ".regs"},   regs_o,     exp_regs);
    if (bus.BREADY) begin
      @(posedge ACLK); #1;
      chk({tag, ".bdone"}, {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                    input string tag);
    bus.ARVALID = 1'b1; bus.ARADDR = a;
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    chk({tag, ".rvalid"}, bus.RVALID, 1);
    chk({tag, ".rdata"},  bus.RDATA,  d);
    chk({tag, ".rresp"},  bus.RRESP,  resp);
    if (bus.RREADY) begin
      @(posedge ACLK); #1;
      chk({tag, ".rdone"}, {bus.RVALID, bus.ARREADY}, 2'b01);
    end
  endtask

  initial begin
    ARESETn     = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = 3'b000;
    bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
    bus.BREADY  = 1'b1;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = 3'b000;
    bus.RREADY  = 1'b1;
    exp_regs    = '0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst.ready",  {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    chk("rst.valid",  {bus.BVALID, bus.RVALID}, 2'b00);
    chk("rst.regs",   regs_o, '0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("idle.valid", {bus.BVALID, bus.RVALID}, 2'b00);
    rd(32'h0C, 32'h0, 2'b00, "rd_reg3_zero");

    exp_regs[63:32] = 32'hDEADBEEF;
    wr(32'h04, 32'hDEADBEEF, 4'b1111, 2'b00, "wr_reg1_full");
    exp_regs[63:32] = 32'hDEAD11EF;
    wr(32'h04, 32'h00001100, 4'b0010, 2'b00, "wr_reg1_byte1");
    rd(32'h04, 32'hDEAD11EF, 2'b00, "rd_reg1");

    // Data three cycles ahead of the address.
    bus.WVALID = 1'b1; bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'b1111;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wfirst.wready", {bus.WREADY, bus.BVALID, bus.AWREADY}, 3'b001);
      if (i < 2) begin
        @(posedge ACLK); #1;
      end
    end
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h08;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    exp_regs[95:64] = 32'hA5A5A5A5;
    chk("wfirst.bvalid", bus.BVALID, 1);
    chk("wfirst.regs",   regs_o, exp_regs);
    @(posedge ACLK); #1;
    chk("wfirst.ready",  {bus.AWREADY, bus.WREADY, bus.BVALID}, 3'b110);

    wr(32'h40, 32'hFFFFFFFF, 4'b1111, 2'b10, "wr_oor");
    rd(32'h44, 32'h0, 2'b10, "rd_oor");

    // Slow reader: response must hold still while RREADY is low.
    bus.RREADY = 1'b0;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h08;
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.rvalid_arready", {bus.RVALID, bus.ARREADY}, 2'b10);
      chk("stall.rdata", bus.RDATA, 32'hA5A5A5A5);
      if (i == 1) begin
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h04;
      end
      @(posedge ACLK); #1;
    end
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;
    @(posedge ACLK); #1;
    chk("stall.release", {bus.RVALID, bus.ARREADY}, 2'b01);

    exp_regs[31:0] = 32'h1;
    wr(32'h00, 32'h1, 4'b1111, 2'b00, "wr_reg0_old");
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h00;
    bus.WVALID  = 1'b1; bus.WDATA  = 32'h2; bus.WSTRB = 4'b1111;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h00;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    exp_regs[31:0] = 32'h2;
    chk("coll.rdata", bus.RDATA, 32'h1);
    chk("coll.valid", {bus.BVALID, bus.RVALID}, 2'b11);
    chk("coll.regs",  regs_o, exp_regs);
    @(posedge ACLK); #1;
    rd(32'h00, 32'h2, 2'b00, "rd_reg0_new");

    // Reset while a response is pending and another W is waiting.
    bus.BREADY = 1'b0;
    exp_regs[191:160] = 32'h55;
    wr(32'h14, 32'h55, 4'b1111, 2'b00, "wr_reg5_hold");
    bus.WVALID = 1'b1; bus.WDATA = 32'h99;
    @(posedge ACLK); #1;
    chk("hold.bvalid", {bus.BVALID, bus.WREADY}, 2'b10);
    #2 ARESETn = 1'b0;
    #1;
    exp_regs = '0;
    chk("midrst.valid", {bus.BVALID, bus.RVALID}, 2'b00);
    chk("midrst.ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    chk("midrst.regs",  regs_o, exp_regs);
    chk("midrst.rdata", {bus.RDATA, bus.RRESP, bus.BRESP}, '0);
    bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // A held W must be forgotten by reset.
    bus.WVALID = 1'b1; bus.WDATA = 32'h77; bus.WSTRB = 4'b1111;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    chk("wheld.wready", bus.WREADY, 0);
    #2 ARESETn = 1'b0;
    #1;
    chk("wheld.rst_wready", bus.WREADY, 1);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h0C;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    chk("fresh.aw_only", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b001);
    chk("fresh.regs_pre", regs_o, exp_regs);
    bus.WVALID = 1'b1; bus.WDATA = 32'h12345678; bus.WSTRB = 4'b1111;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    exp_regs[127:96] = 32'h12345678;
    chk("fresh.bvalid", {bus.BVALID, bus.BRESP}, 3'b100);
    chk("fresh.regs",   regs_o, exp_regs);
    @(posedge ACLK); #1;
    chk("fresh.done",   {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
